dma_2d_read_master: RTL and testbench
=====================================

# dma_2d_read_master

AXI4-Full read master for the 2D DMA: fetches `i_img_height` rows of `i_img_width` bytes, with row start addresses spaced `i_img_stride` bytes apart from `i_src_addr`. It pushes every returned beat, in order, into the downstream source FIFO. It is the read-side counterpart of the 2D write master and sits on the M00 AXI port of the DMA top. Only the read channels are implemented; the top ties off the write channels.

## Interface
- C_M_AXI_BURST_LEN, 64, max beats per burst (1..256)
- C_M_AXI_ID_WIDTH, 1, AXI ID width
- C_M_AXI_ADDR_WIDTH, 32, address width
- C_M_AXI_DATA_WIDTH, 32, data width (only 32 supported)

Ports:
- M_AXI_ACLK  in  1  single clock
- M_AXI_ARESETN  in  1  asynchronous, active-low reset
- i_start  in  1  one-cycle start pulse; ignored while busy
- i_src_addr  in  32  first row byte address, word aligned
- i_img_width  in  32  bytes per row; bits[1:0] ignored
- i_img_height  in  32  number of rows
- i_img_stride  in  32  byte distance between row starts
- o_r_data  out  32  FIFO write data (= M_AXI_RDATA)
- i_fifo_full  in  1  FIFO full
- o_fifo_wr_en  out  1  FIFO push
- o_busy  out  1  transfer in progress
- o_read_done  out  1  one-cycle completion pulse
- M_AXI_ARID/ARADDR/ARLEN[7:0]/ARSIZE[2:0]/ARBURST[1:0]/ARLOCK/ARCACHE[3:0]/ARPROT[2:0]/ARQOS[3:0]/ARVALID  out  AR channel
- M_AXI_ARREADY  in  1
- M_AXI_RID  in  ID width; M_AXI_RDATA  in  32; M_AXI_RRESP  in  2; M_AXI_RLAST  in  1; M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1
- ERROR  out  1  sticky: RRESP != OKAY or RLAST mismatch

## Operation
- Fixed AR fields: ARID=0, ARSIZE=3'b010, ARBURST=INCR, ARLOCK=0, ARCACHE=4'b0010, ARPROT=0, ARQOS=0.
- On i_start in IDLE, latch all parameters and clear ERROR.
  - words_per_row = width>>2.
  - If words_per_row==0 or height==0: go to DONE with no AXI traffic.
- States:
  - IDLE -> ADDR on accepted start.
  - ADDR: ARVALID=1, ARADDR/ARLEN held stable; on ARREADY -> DATA.
  - DATA: RREADY = !i_fifo_full; beat accepted when RVALID&&RREADY; o_fifo_wr_en = same condition, combinational.
    - Last beat of burst, row words remaining -> ADDR.
    - Last beat, row finished, rows remaining -> ADDR at row_base+stride.
    - Last beat of last row -> DONE.
  - DONE: o_read_done=1 for one cycle -> IDLE.
- One outstanding burst at a time.
- Burst length = min(row words remaining, C_M_AXI_BURST_LEN, words to 4 KB boundary when the macro is enabled); ARLEN = length-1.
- Address arithmetic: 32-bit, wraps modulo 2^32; no error on wrap.
- Beat counter defines burst end. RLAST high on a non-final beat, or low on the final beat, sets ERROR; the counter still governs completion.
- RRESP != 2'b00 on any beat sets ERROR; data is still pushed and the transfer continues to completion.
- ERROR holds until the next accepted start or reset.
- o_busy = state != IDLE.

## Timing
- Reset (async assert, sync deassert external): state IDLE. All outputs 0: ARVALID, RREADY, ARADDR, ARLEN, o_fifo_wr_en, o_busy, o_read_done, ERROR.
- Start sampled at edge N: ARVALID high from edge N+1.
- Burst-to-burst: ARVALID for the next burst high the cycle after the final beat is accepted.
- o_read_done high the cycle after the final beat is accepted.
- Zero-size job: o_read_done at N+1, N+2 no ARVALID.
- Reset mid-transfer: abort immediately to IDLE, no done pulse. Residual R beats after reset are not captured (RREADY=0).
- RREADY drops in the same cycle i_fifo_full rises; no push while full.

## Configuration
- DMA_RD_4K_SPLIT_EN defined: a burst never crosses a 4 KB boundary. Length is capped at (4096 - ARADDR[11:0])>>2 words.
- Undefined: no split; software guarantees bursts do not cross 4 KB.

## Test plan
- src=0x1000_0000, width=256, height=2, stride=1024, BURST_LEN=64 -> two AR: 0x1000_0000 and 0x1000_0400, each ARLEN=63. 128 pushes, data in order, one done pulse, ERROR=0.
- width=20, height=1 -> one AR, ARLEN=4, 5 pushes. width=3 -> no AR, done at N+1.
- src=0x0000_0FC0, width=256, height=1:
  - Macro defined: AR 0x0FC0 ARLEN=15, then 0x1000 ARLEN=47.
  - Undefined: single AR ARLEN=63.
- i_fifo_full high 5 cycles during beat 10 of a 64-beat burst, slave RVALID continuous -> RREADY low exactly 5 cycles, no pushes, 64 pushes total, order intact.
- RRESP=SLVERR on beat 3 -> ERROR=1 from next cycle, all beats pushed, done pulses. Next start clears ERROR.
- ARESETN low during DATA -> all outputs 0 asynchronously, no done. New start after release runs correctly. ARREADY delayed 7 cycles -> ARADDR/ARLEN stable throughout.

Source files
------------

// File: rtl/dma_2d_read_master_if.sv
// AXI4 read-channel bundle (AR + R) between the 2D DMA read master and the M00 slave.
interface dma_2d_read_master_if #(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
);
  logic [C_M_AXI_ID_WIDTH-1:0]   ARID;
  logic [C_M_AXI_ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]                    ARLEN;
  logic [2:0]                    ARSIZE;
  logic [1:0]                    ARBURST;
  logic                          ARLOCK;
  logic [3:0]                    ARCACHE;
  logic [2:0]                    ARPROT;
  logic [3:0]                    ARQOS;
  logic                          ARVALID;
  logic                          ARREADY;
  logic [C_M_AXI_ID_WIDTH-1:0]   RID;
  logic [C_M_AXI_DATA_WIDTH-1:0] RDATA;
  logic [1:0]                    RRESP;
  logic                          RLAST;
  logic                          RVALID;
  logic                          RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/dma_2d_read_master.sv
// 2D DMA AXI4 read master: fetches height rows of width bytes spaced by stride, pushing beats to a FIFO.
// Optional macro DMA_RD_4K_SPLIT_EN: split bursts so none crosses a 4 KB boundary.
module dma_2d_read_master #(
  parameter int C_M_AXI_BURST_LEN  = 64,
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          i_start,
  input  logic [31:0]                   i_src_addr,
  input  logic [31:0]                   i_img_width,
  input  logic [31:0]                   i_img_height,
  input  logic [31:0]                   i_img_stride,
  output logic [C_M_AXI_DATA_WIDTH-1:0] o_r_data,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_wr_en,
  output logic                          o_busy,
  output logic                          o_read_done,
  dma_2d_read_master_if.master          m_axi,
  output logic                          ERROR
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  localparam logic [8:0] MAX_LEN = 9'(C_M_AXI_BURST_LEN);

  state_t      state;
  logic [31:0] araddr, row_base, stride, words_row, words_left, rows_left;
  logic [7:0]  arlen, beat_cnt;
  logic        arvalid, read_done, error;

  logic [8:0]  blen, nxt_len;
  logic [31:0] cont_addr, cont_rem, nxt_addr, nxt_rem;
  logic        row_done, rready, beat, last_beat;
  logic        unused_bits;
`ifdef DMA_RD_4K_SPLIT_EN
  logic [12:0] to_4k;
`endif

  assign blen      = {1'b0, arlen} + 9'd1;
  assign cont_addr = araddr + {21'd0, blen, 2'b00};
  assign cont_rem  = words_left - {23'd0, blen};
  assign row_done  = (cont_rem == 32'd0);

  // Next burst: first row on start, rest of the current row, or the start of the next row.
  always_comb begin
    if (state == IDLE) begin
      nxt_addr = i_src_addr;
      nxt_rem  = {2'b00, i_img_width[31:2]};
    end else if (!row_done) begin
      nxt_addr = cont_addr;
      nxt_rem  = cont_rem;
    end else begin
      nxt_addr = row_base + stride;
      nxt_rem  = words_row;
    end
    nxt_len = (nxt_rem > {23'd0, MAX_LEN}) ? MAX_LEN : nxt_rem[8:0];
`ifdef DMA_RD_4K_SPLIT_EN
    to_4k = (13'd4096 - {1'b0, nxt_addr[11:0]}) >> 2;
    if ({4'd0, nxt_len} > to_4k) nxt_len = to_4k[8:0];
`endif
  end

  assign rready    = (state == DATA) && !i_fifo_full;
  assign beat      = m_axi.RVALID && rready;
  assign last_beat = (beat_cnt == arlen);

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state      <= IDLE;
      araddr     <= '0;
      row_base   <= '0;
      stride     <= '0;
      words_row  <= '0;
      words_left <= '0;
      rows_left  <= '0;
      arlen      <= '0;
      beat_cnt   <= '0;
      arvalid    <= 1'b0;
      read_done  <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          read_done <= 1'b0;
          if (i_start) begin
            row_base  <= i_src_addr;
            stride    <= i_img_stride;
            words_row <= {2'b00, i_img_width[31:2]};
            rows_left <= i_img_height;
            error     <= 1'b0;
            beat_cnt  <= '0;
            if (i_img_width[31:2] == 30'd0 || i_img_height == 32'd0) begin
              state     <= DONE;
              read_done <= 1'b1;
            end else begin
              state      <= ADDR;
              arvalid    <= 1'b1;
              araddr     <= nxt_addr;
              arlen      <= 8'(nxt_len - 9'd1);
              words_left <= nxt_rem;
            end
          end
        end
        ADDR: begin
          if (m_axi.ARREADY) begin
            arvalid <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            // RLAST is only checked; the local beat count decides where the burst ends.
            if (m_axi.RRESP != 2'b00 || m_axi.RLAST != last_beat) error <= 1'b1;
            if (last_beat) begin
              beat_cnt <= '0;
              if (!row_done || rows_left > 32'd1) begin
                if (row_done) begin
                  rows_left <= rows_left - 32'd1;
                  row_base  <= nxt_addr;
                end
                state      <= ADDR;
                arvalid    <= 1'b1;
                araddr     <= nxt_addr;
                arlen      <= 8'(nxt_len - 9'd1);
                words_left <= nxt_rem;
              end else begin
                state     <= DONE;
                read_done <= 1'b1;
              end
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        default: begin
          read_done <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign m_axi.ARID    = {C_M_AXI_ID_WIDTH{1'b0}};
  assign m_axi.ARADDR  = C_M_AXI_ADDR_WIDTH'(araddr);
  assign m_axi.ARLEN   = arlen;
  assign m_axi.ARSIZE  = 3'b010;
  assign m_axi.ARBURST = 2'b01;
  assign m_axi.ARLOCK  = 1'b0;
  assign m_axi.ARCACHE = 4'b0010;
  assign m_axi.ARPROT  = 3'b000;
  assign m_axi.ARQOS   = 4'b0000;
  assign m_axi.ARVALID = arvalid;
  assign m_axi.RREADY  = rready;

  assign o_r_data     = m_axi.RDATA;
  assign o_fifo_wr_en = beat;
  assign o_busy       = (state != IDLE);
  assign o_read_done  = read_done;
  assign ERROR        = error;

  assign unused_bits = ^{m_axi.RID, i_img_width[1:0]};

endmodule

// File: tb/tb_dma_2d_read_master.sv
// Directed bench for dma_2d_read_master: AXI read slave returns each beat's byte address as data.
module tb_dma_2d_read_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, fifo_full;
  logic [31:0] src, width, height, stride;
  logic [31:0] r_data;
  logic        wr_en, busy, read_done, error;

  always #5 clk = ~clk;

  dma_2d_read_master_if axi ();

  dma_2d_read_master dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .i_start       (start),
    .i_src_addr    (src),
    .i_img_width   (width),
    .i_img_height  (height),
    .i_img_stride  (stride),
    .o_r_data      (r_data),
    .i_fifo_full   (fifo_full),
    .o_fifo_wr_en  (wr_en),
    .o_busy        (busy),
    .o_read_done   (read_done),
    .m_axi         (axi),
    .ERROR         (error)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model state
  int          ar_delay = 0;
  int          ar_wait, r_left, beat_idx;
  int          err_beat = -1;
  int          bad_last_beat = -1;
  bit          ar_take, r_take, in_burst, ar_seen;
  logic [31:0] r_addr, ar_hold_addr;
  logic [7:0]  ar_hold_len;
  int          ar_unstable;
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];

  // Monitors
  logic [31:0] push_q[$];
  int cyc = 0, last_push_cyc = 0, done_cyc = 0;
  int done_cnt, stall_cnt, bad_push;

  initial begin
    axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RDATA = '0;
    axi.RRESP = 2'b00; axi.RLAST = 1'b0; axi.RID = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RLAST = 1'b0;
        in_burst = 0; ar_take = 0; r_take = 0; ar_wait = 0; ar_seen = 0;
      end else begin
        if (ar_take) begin
          axi.ARREADY = 1'b0;
          in_burst = 1;
          r_addr = ar_hold_addr;
          r_left = int'(ar_hold_len) + 1;
          ar_wait = 0;
          ar_seen = 0;
        end
        if (r_take) begin
          r_addr = r_addr + 32'd4;
          r_left--;
          beat_idx++;
          if (r_left == 0) in_burst = 0;
        end
        if (!in_burst && axi.ARVALID && !axi.ARREADY) begin
          if (!ar_seen) begin
            ar_seen = 1; ar_hold_addr = axi.ARADDR; ar_hold_len = axi.ARLEN;
          end else if (axi.ARADDR !== ar_hold_addr || axi.ARLEN !== ar_hold_len) begin
            ar_unstable++;
          end
          if (ar_wait >= ar_delay) begin
            axi.ARREADY = 1'b1;
            ar_addr_q.push_back(ar_hold_addr);
            ar_len_q.push_back(ar_hold_len);
          end else begin
            ar_wait++;
          end
        end
        if (in_burst) begin
          axi.RVALID = 1'b1;
          axi.RDATA  = r_addr;
          axi.RLAST  = (r_left == 1) ^ (beat_idx == bad_last_beat);
          axi.RRESP  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
        end else begin
          axi.RVALID = 1'b0; axi.RLAST = 1'b0; axi.RRESP = 2'b00;
        end
        ar_take = axi.ARVALID && axi.ARREADY;
        r_take  = axi.RVALID && axi.RREADY;
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (wr_en) begin
      push_q.push_back(r_data);
      last_push_cyc = cyc;
      if (fifo_full) bad_push++;
    end
    if (axi.RVALID && !axi.RREADY) stall_cnt++;
  end

  always @(negedge clk) begin
    if (read_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_logs();
    push_q.delete(); ar_addr_q.delete(); ar_len_q.delete();
    done_cnt = 0; stall_cnt = 0; bad_push = 0; beat_idx = 0; ar_unstable = 0;
  endtask

  task automatic kick(input logic [31:0] s, input logic [31:0] w, input logic [31:0] h,
                      input logic [31:0] st);
    clear_logs();
    @(posedge clk); #1;
    src = s; width = w; height = h; stride = st; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 3000 && done_cnt == 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_pushes(input int n);
    for (int k = 0; k < 3000 && push_q.size() < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_data(input string tag, input logic [31:0] s, input int words,
                            input int rows, input logic [31:0] st);
    int bad = 0;
    int idx = 0;
    for (int r = 0; r < rows; r++)
      for (int i = 0; i < words; i++) begin
        if (idx >= push_q.size() || push_q[idx] !== s + st * r + 32'(4 * i)) bad++;
        idx++;
      end
    chk({tag, "_push_count"}, push_q.size(), words * rows);
    chk({tag, "_data_order"}, bad, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; fifo_full = 1'b0;
    src = '0; width = '0; height = '0; stride = '0;
    repeat (3) @(negedge clk);
    chk("rst_arvalid", axi.ARVALID, 0);
    chk("rst_rready", axi.RREADY, 0);
    chk("rst_araddr", axi.ARADDR, 0);
    chk("rst_arlen", axi.ARLEN, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", read_done, 0);
    chk("rst_error", error, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Two rows of 64 words, stride 1 KB
    kick(32'h1000_0000, 256, 2, 1024);
    chk("t1_arvalid_n1", axi.ARVALID, 1);
    chk("t1_busy", busy, 1);
    chk("t1_fixed_ar", {axi.ARSIZE, axi.ARBURST, axi.ARCACHE, axi.ARLOCK, axi.ARPROT, axi.ARQOS},
        {3'b010, 2'b01, 4'b0010, 1'b0, 3'b000, 4'b0000});
    wait_done();
    chk("t1_ar_count", ar_addr_q.size(), 2);
    chk("t1_ar0_addr", ar_addr_q[0], 32'h1000_0000);
    chk("t1_ar0_len", ar_len_q[0], 63);
    chk("t1_ar1_addr", ar_addr_q[1], 32'h1000_0400);
    chk("t1_ar1_len", ar_len_q[1], 63);
    check_data("t1", 32'h1000_0000, 64, 2, 1024);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_after_last", done_cyc - last_push_cyc, 0);
    chk("t1_error", error, 0);
    chk("t1_busy_end", busy, 0);

    // Short row: 5 words
    kick(32'h2000_0010, 20, 1, 0);
    wait_done();
    chk("t2_ar_count", ar_addr_q.size(), 1);
    chk("t2_ar0_addr", ar_addr_q[0], 32'h2000_0010);
    chk("t2_ar0_len", ar_len_q[0], 4);
    check_data("t2", 32'h2000_0010, 5, 1, 0);
    chk("t2_done_cnt", done_cnt, 1);

    // Width below one word: no traffic, done right away
    kick(32'h2000_0000, 3, 4, 0);
    chk("t3_done_n1", read_done, 1);
    chk("t3_arvalid_n1", axi.ARVALID, 0);
    @(posedge clk); #1;
    chk("t3_done_n2", read_done, 0);
    chk("t3_arvalid_n2", axi.ARVALID, 0);
    chk("t3_busy_n2", busy, 0);
    repeat (3) @(posedge clk);
    chk("t3_ar_count", ar_addr_q.size(), 0);

    // 75-word rows split 64+11, two rows stride 0x200
    kick(32'h4000_0000, 300, 2, 32'h200);
    wait_done();
    chk("t4_ar_count", ar_addr_q.size(), 4);
    chk("t4_ar1_addr", ar_addr_q[1], 32'h4000_0100);
    chk("t4_ar1_len", ar_len_q[1], 10);
    chk("t4_ar2_addr", ar_addr_q[2], 32'h4000_0200);
    chk("t4_ar3_addr", ar_addr_q[3], 32'h4000_0300);
    chk("t4_ar3_len", ar_len_q[3], 10);
    check_data("t4", 32'h4000_0000, 75, 2, 32'h200);

    // Row starting 64 bytes below a 4 KB boundary
    kick(32'h0000_0FC0, 256, 1, 0);
    wait_done();
`ifdef DMA_RD_4K_SPLIT_EN
    chk("t5_ar_count", ar_addr_q.size(), 2);
    chk("t5_ar0_len", ar_len_q[0], 15);
    chk("t5_ar1_addr", ar_addr_q[1], 32'h0000_1000);
    chk("t5_ar1_len", ar_len_q[1], 47);
`else
    chk("t5_ar_count", ar_addr_q.size(), 1);
    chk("t5_ar0_len", ar_len_q[0], 63);
`endif
    chk("t5_ar0_addr", ar_addr_q[0], 32'h0000_0FC0);
    check_data("t5", 32'h0000_0FC0, 64, 1, 0);

    // FIFO full for 5 cycles at beat 10
    kick(32'h3000_0000, 256, 1, 0);
    wait_pushes(10);
    fifo_full = 1'b1;
    repeat (5) @(posedge clk);
    #1 fifo_full = 1'b0;
    wait_done();
    chk("t6_stall_cycles", stall_cnt, 5);
    chk("t6_push_while_full", bad_push, 0);
    check_data("t6", 32'h3000_0000, 64, 1, 0);

    // SLVERR on beat 3
    err_beat = 3;
    kick(32'h5000_0000, 64, 1, 0);
    wait_pushes(3);
    chk("t7_error_before", error, 0);
    wait_pushes(4);
    chk("t7_error_after", error, 1);
    wait_done();
    err_beat = -1;
    chk("t7_error_sticky", error, 1);
    check_data("t7", 32'h5000_0000, 16, 1, 0);
    chk("t7_done_cnt", done_cnt, 1);
    kick(32'h5000_1000, 8, 1, 0);
    chk("t7_error_cleared", error, 0);
    wait_done();
    chk("t7_clean_error", error, 0);

    // Early RLAST on beat 0
    bad_last_beat = 0;
    kick(32'h5000_2000, 16, 1, 0);
    wait_done();
    bad_last_beat = -1;
    chk("t8_rlast_error", error, 1);
    check_data("t8", 32'h5000_2000, 4, 1, 0);

    // Reset during the data phase
    kick(32'h6000_0000, 256, 1, 0);
    wait_pushes(20);
    #2 rst_n = 1'b0;
    #1;
    chk("t9_arvalid", axi.ARVALID, 0);
    chk("t9_rready", axi.RREADY, 0);
    chk("t9_wr_en", wr_en, 0);
    chk("t9_busy", busy, 0);
    chk("t9_araddr", axi.ARADDR, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    chk("t9_no_done", done_cnt, 0);

    // Restart after reset with a slow ARREADY
    ar_delay = 7;
    kick(32'h7000_0040, 16, 1, 0);
    wait_done();
    chk("t10_ar_count", ar_addr_q.size(), 1);
    chk("t10_ar0_addr", ar_addr_q[0], 32'h7000_0040);
    chk("t10_ar0_len", ar_len_q[0], 3);
    chk("t10_ar_stable", ar_unstable, 0);
    check_data("t10", 32'h7000_0040, 4, 1, 0);
    chk("t10_done_cnt", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
